// File: rtl/wb_regfile_pkg.sv
// Shared widths and constants for the write-back stage and architectural register file.
package wb_regfile_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/register32bit.sv
// Single register-file entry: asynchronous clear, load on write enable.
module register32bit #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (we) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/wb_regfile_decoder.sv
// One-hot write-enable decoder for register entries 1..N-1, gated by i_en.
module decoder5to32
    import wb_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = wb_regfile_pkg::REG_ADDR_W
) (
    input  logic                       i_en,
    input  logic [ADDR_W-1:0]          i_addr,
    output logic [(1 << ADDR_W)-1:1]   o_we
);

    localparam int unsigned N = 1 << ADDR_W;

    // Entry 0 has no storage, so no enable is produced for it.
    always_comb begin
        o_we = '0;
        for (int unsigned i = 1; i < N; i++) begin
            o_we[i] = i_en && (i_addr == ADDR_W'(i));
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back select, 32-entry register file with hardwired $0, and two
// combinational read ports with write-through bypass from the WB stage.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int unsigned DATA_W     = wb_regfile_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W = wb_regfile_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memToReg_MEM_WB,
    input  logic                  regWrite_MEM_WB,
    input  logic [REG_ADDR_W-1:0] destReg_MEM_WB,
    input  logic [DATA_W-1:0]     memData_MEM_WB,
    input  logic [DATA_W-1:0]     aluOut_MEM_WB,
    input  logic [REG_ADDR_W-1:0] rsAddr,
    input  logic [REG_ADDR_W-1:0] rtAddr,
    output logic [DATA_W-1:0]     rsData,
    output logic [DATA_W-1:0]     rtData,
    output logic [DATA_W-1:0]     wbData,
    output logic                  wbValid
);

    localparam int unsigned N = 1 << REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] W_ZERO_IDX = REG_ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]       w_wb_data;
    logic                    w_wb_valid;
    logic [N-1:1]            w_we;
    logic [N-1:0][DATA_W-1:0] w_q;

    assign w_wb_data  = memToReg_MEM_WB ? memData_MEM_WB : aluOut_MEM_WB;
    assign w_wb_valid = regWrite_MEM_WB && (destReg_MEM_WB != W_ZERO_IDX) && !reset;

    decoder5to32 #(
        .ADDR_W (REG_ADDR_W)
    ) u_dec (
        .i_en   (w_wb_valid),
        .i_addr (destReg_MEM_WB),
        .o_we   (w_we)
    );

    assign w_q[0] = '0;

    for (genvar g = 1; g < N; g++) begin : g_entry
        register32bit #(
            .W (DATA_W)
        ) u_reg (
            .clk   (clk),
            .reset (reset),
            .we    (w_we[g]),
            .d     (w_wb_data),
            .q     (w_q[g])
        );
    end

    // $0 check precedes the bypass so a zero-index read never sees WB data.
    always_comb begin
        rsData = w_q[rsAddr];
        if (rsAddr == W_ZERO_IDX) begin
            rsData = '0;
        end else if (w_wb_valid && (rsAddr == destReg_MEM_WB)) begin
            rsData = w_wb_data;
        end
    end

    always_comb begin
        rtData = w_q[rtAddr];
        if (rtAddr == W_ZERO_IDX) begin
            rtData = '0;
        end else if (w_wb_valid && (rtAddr == destReg_MEM_WB)) begin
            rtData = w_wb_data;
        end
    end

    assign wbData  = w_wb_data;
    assign wbValid = w_wb_valid;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized
// traffic checked against an array-based architectural model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        memToReg_MEM_WB;
    logic        regWrite_MEM_WB;
    logic [4:0]  destReg_MEM_WB;
    logic [31:0] memData_MEM_WB;
    logic [31:0] aluOut_MEM_WB;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [31:0] wbData;
    logic        wbValid;

    logic [31:0] model [32];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    wb_regfile #(
        .DATA_W     (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .memToReg_MEM_WB (memToReg_MEM_WB),
        .regWrite_MEM_WB (regWrite_MEM_WB),
        .destReg_MEM_WB  (destReg_MEM_WB),
        .memData_MEM_WB  (memData_MEM_WB),
        .aluOut_MEM_WB   (aluOut_MEM_WB),
        .rsAddr          (rsAddr),
        .rtAddr          (rtAddr),
        .rsData          (rsData),
        .rtData          (rtData),
        .wbData          (wbData),
        .wbValid         (wbValid)
    );

    function automatic logic [31:0] ref_sel();
        return memToReg_MEM_WB ? memData_MEM_WB : aluOut_MEM_WB;
    endfunction

    function automatic logic ref_valid();
        return regWrite_MEM_WB && (destReg_MEM_WB != 5'd0) && !reset;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (ref_valid() && a == destReg_MEM_WB) return ref_sel();
        return model[a];
    endfunction

    task automatic set_in(input logic rw, input logic m2r, input logic [4:0] dst,
                          input logic [31:0] md, input logic [31:0] ao,
                          input logic [4:0] rs, input logic [4:0] rt);
        regWrite_MEM_WB = rw;
        memToReg_MEM_WB = m2r;
        destReg_MEM_WB  = dst;
        memData_MEM_WB  = md;
        aluOut_MEM_WB   = ao;
        rsAddr          = rs;
        rtAddr          = rt;
    endtask

    // Advance one cycle; the model commits what was presented at the edge.
    task automatic clk_edge();
        @(posedge clk);
        if (ref_valid()) model[destReg_MEM_WB] = ref_sel();
        @(negedge clk);
    endtask

    task automatic test_reset_initial();
        for (int a = 0; a < 32; a++) begin
            rsAddr = 5'(a);
            rtAddr = 5'(31 - a);
            #1;
            vectors++;
            if (rsData !== 32'h0 || rtData !== 32'h0 || wbValid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_initial idx=%0d rs=%h rt=%h wbValid=%b required 0/0/0",
                         a, rsData, rtData, wbValid);
            end
        end
    endtask

    task automatic test_reset_midop();
        for (int i = 1; i < 32; i++) begin
            set_in(1'b1, 1'($urandom_range(1)), 5'(i), $urandom, $urandom, 5'd0, 5'd0);
            clk_edge();
        end
        set_in(1'b1, 1'b0, 5'd3, $urandom, $urandom | 32'h1, 5'd3, 5'd5);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        vectors++;
        if (rsData !== 32'h0 || rtData !== 32'h0 || wbValid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async rs=%h rt=%h wbValid=%b required 0/0/0", rsData, rtData, wbValid);
        end
        for (int a = 0; a < 32; a++) begin
            set_in(1'b1, 1'($urandom_range(1)), 5'($urandom), $urandom, $urandom, 5'(a), 5'(31 - a));
            #1;
            vectors++;
            if (rsData !== 32'h0 || rtData !== 32'h0 || wbValid !== 1'b0 || wbData !== ref_sel()) begin
                miscompares++;
                $display("FAIL reset_hold idx=%0d rs=%h rt=%h wbValid=%b wbData=%h required 0/0/0/%h",
                         a, rsData, rtData, wbValid, wbData, ref_sel());
            end
        end
        @(negedge clk);
        reset = 1'b0;
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    endtask

    task automatic test_basic();
        set_in(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b1, 1'b1, 5'd31, 32'h12345678, 32'h0BADF00D, 5'd5, 5'd1);
        clk_edge();
        regWrite_MEM_WB = 1'b0;
        rtAddr = 5'd31;
        #1;
        vectors++;
        if (rsData !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL basic_alu got=%h required=%h", rsData, 32'hDEADBEEF);
        end
        vectors++;
        if (rtData !== 32'h12345678) begin
            miscompares++;
            $display("FAIL basic_mem got=%h required=%h", rtData, 32'h12345678);
        end
    endtask

    task automatic test_bypass();
        set_in(1'b1, 1'b0, 5'd7, 32'h0, 32'h1, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b1, 1'b0, 5'd7, 32'h0, 32'hCAFEF00D, 5'd7, 5'd7);
        #1;
        vectors++;
        if (rsData !== 32'hCAFEF00D || rtData !== 32'hCAFEF00D || wbValid !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_hit rs=%h rt=%h wbValid=%b required CAFEF00D/CAFEF00D/1",
                     rsData, rtData, wbValid);
        end
        regWrite_MEM_WB = 1'b0;
        #1;
        vectors++;
        if (rsData !== 32'h1 || rtData !== 32'h1 || wbValid !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_off rs=%h rt=%h wbValid=%b required 1/1/0", rsData, rtData, wbValid);
        end
        clk_edge();
    endtask

    task automatic test_zero();
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        vectors++;
        if (wbValid !== 1'b0 || rsData !== 32'h0 || wbData !== 32'hFFFFFFFF) begin
            miscompares++;
            $display("FAIL zero_same wbValid=%b rs=%h wbData=%h required 0/0/FFFFFFFF",
                     wbValid, rsData, wbData);
        end
        clk_edge();
        regWrite_MEM_WB = 1'b0;
        #1;
        vectors++;
        if (rsData !== 32'h0 || rtData !== 32'h0) begin
            miscompares++;
            $display("FAIL zero_next rs=%h rt=%h required 0/0", rsData, rtData);
        end
    endtask

    task automatic test_reset_during_write();
        set_in(1'b1, 1'b0, 5'd9, 32'h0, 32'hA5A5A5A5, 5'd9, 5'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        clk_edge();
        reset = 1'b0;
        regWrite_MEM_WB = 1'b0;
        #1;
        vectors++;
        if (rsData !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_write_lost got=%h required=0", rsData);
        end
        regWrite_MEM_WB = 1'b1;
        clk_edge();
        regWrite_MEM_WB = 1'b0;
        #1;
        vectors++;
        if (rsData !== 32'hA5A5A5A5) begin
            miscompares++;
            $display("FAIL reset_then_commit got=%h required=A5A5A5A5", rsData);
        end
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 1'b0, 5'd3, 32'h0, 32'h11, 5'd3, 5'd3);
        #1;
        vectors++;
        if (rsData !== 32'h11) begin
            miscompares++;
            $display("FAIL b2b_first got=%h required=11", rsData);
        end
        clk_edge();
        aluOut_MEM_WB = 32'h22;
        #1;
        vectors++;
        if (rsData !== 32'h22) begin
            miscompares++;
            $display("FAIL b2b_second got=%h required=22", rsData);
        end
        clk_edge();
        regWrite_MEM_WB = 1'b0;
        #1;
        vectors++;
        if (rsData !== 32'h22) begin
            miscompares++;
            $display("FAIL b2b_stored got=%h required=22", rsData);
        end
    endtask

    task automatic test_random();
        logic [4:0] dst;
        for (int n = 0; n < 400; n++) begin
            dst = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
            set_in(1'($urandom_range(3) != 0), 1'($urandom_range(1)), dst, $urandom, $urandom,
                   ($urandom_range(2) == 0) ? dst : 5'($urandom),
                   ($urandom_range(2) == 0) ? dst : 5'($urandom));
            #1;
            vectors++;
            if (rsData !== ref_read(rsAddr) || rtData !== ref_read(rtAddr) ||
                wbData !== ref_sel() || wbValid !== ref_valid()) begin
                miscompares++;
                $display("FAIL random n=%0d rs[%0d]=%h/%h rt[%0d]=%h/%h wb=%h/%h v=%b/%b (got/required)",
                         n, rsAddr, rsData, ref_read(rsAddr), rtAddr, rtData, ref_read(rtAddr),
                         wbData, ref_sel(), wbValid, ref_valid());
            end
            clk_edge();
        end
    endtask

    initial begin
        reset = 1'b1;
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clk);
        test_reset_initial();
        @(negedge clk);
        reset = 1'b0;
        test_basic();
        test_bypass();
        test_zero();
        test_random();
        test_reset_midop();
        test_reset_during_write();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
